microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Control-unit next-state engine. Consumes the sequencing fields of the 64-bit microinstruction word from the control ROM and produces the registered 8-bit state that addresses that ROM.
- Closes the ROM → sequencer → ROM loop. Selects the next state from four sources: the instruction encoder address, the microbranch targets CR_HI/CR_LO, the incrementer, or the current state (hold).
- Adds a memory-wait watchdog and an interrupt override.

Parameters:
- RESET_STATE, 8'd0, state loaded on reset.
- IRQ_STATE, 8'd44, state forced when an interrupt is taken.
- WAIT_LIMIT, 16, max consecutive wait cycles before timeout (range 1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- cw  in  64  current control word from the ROM. Sequencer uses:
  - [57:55] N
  - [54] INV
  - [53] MI
  - [52:50] S
  - [49:42] CR_HI
  - [41:34] CR_LO
- enc_addr  in  8  start state from the instruction encoder.
- moc  in  1  memory operation complete.
- cond_pass  in  1  ARM condition-code test passed.
- flag_n, flag_z, flag_c, flag_v  in  1 each  status flags.
- lsm_done  in  1  load/store-multiple register list exhausted.
- irq_req  in  1  interrupt request, level.
- state  out  8  registered ROM address.
- cond  out  1  evaluated condition, combinational, for debug.
- timeout  out  1  one-cycle pulse when the wait watchdog fires.

Behaviour:
- Reset:
  - CLR high asynchronously forces state=RESET_STATE, wait_cnt=0, timeout=0.
  - CLR has priority over everything. Deassertion mid-operation restarts at RESET_STATE on the next edge with no carried wait count.
- Condition (combinational):
  - raw selected by S: 000 moc, 001 cond_pass, 010 flag_z, 011 flag_n, 100 flag_c, 101 flag_v, 110 lsm_done, 111 constant 1.
  - cond = raw XOR INV.
- Incrementer: incr = state+1, 8-bit, wraps 8'hFF→8'h00.
- N-select next state (nx):
  - 000 enc_addr
  - 001 CR_HI
  - 010 incr
  - 011 cond ? CR_HI : incr
  - 100 cond ? CR_HI : CR_LO
  - 101 cond ? CR_HI : enc_addr
  - 110 cond ? state : incr (wait/hold)
  - 111 state (unconditional hold)
- Wait watchdog:
  - A cycle is a wait cycle when N=110 and cond=1.
  - wait_cnt increments on each wait cycle and clears on any non-wait cycle.
  - When a wait cycle occurs with wait_cnt==WAIT_LIMIT-1: nx is overridden to CR_LO, timeout=1 for that one cycle, wait_cnt clears.
  - N=111 never times out.
- Interrupt: when MI=1 and irq_req=1, nx is overridden to IRQ_STATE and wait_cnt clears.
- Priority: CLR > timeout > interrupt > N-select.
  - A simultaneous timeout and interrupt takes the timeout.
  - The interrupt is not latched; it re-evaluates on the next MI=1 state.
- Registering:
  - state <= final nx on every rising CLK edge.
  - Latency from a cw/input change to the new state is one cycle.
  - timeout is registered alongside state, so it is visible in the cycle the CR_LO state is presented.
- No X propagation: unused cw bits are ignored. An undefined ROM row (all zeros) gives N=000 and follows enc_addr.

Decomposition:
- Shared package (control_pkg):
  - cw field bit-position constants for N, INV, MI, S, CR_HI, CR_LO.
  - N-select encodings (NS_ENC, NS_CRHI, NS_INC, NS_CBR, NS_C2, NS_CENC, NS_WAIT, NS_HOLD).
  - S condition encodings.
  - Default RESET_STATE and IRQ_STATE.
- One sub-module: cond_select, the 8:1 condition mux plus INV. It is pure combinational and reused by the verification model.
- The next-address mux, watchdog counter and state register stay in microsequencer.

Test Plan:
1. Reset and fetch chain: CLR pulse mid-cycle, then N=010 for 3 cycles from state 0 → state goes 0 asynchronously, then 1, 2, 3. Also state 8'hFF with N=010 → 8'h00.
2. Decode dispatch: state=3, N=000, enc_addr=8'd25 → next state 25. Then N=100, S=001, cond_pass=0, CR_HI=30, CR_LO=40 → 40; with cond_pass=1 → 30.
3. Memory wait: N=110, S=000, INV=1, moc=0 for 3 cycles then moc=1 → state held 3 cycles, then incr. timeout stays 0 and wait_cnt returns to 0.
4. Watchdog: WAIT_LIMIT=4, moc stuck 0, CR_LO=8'd50 → held for exactly 3 edges; 4th edge loads 50 with timeout=1 for one cycle, then timeout=0.
5. Interrupt: MI=1, irq_req=1, N=010 → state=IRQ_STATE (44). Same with MI=0 → incr. Interrupt coinciding with watchdog expiry → CR_LO wins.
6. Condition mux sweep: each S with raw 0/1 and INV 0/1 → cond equals raw XOR INV for all 32 combinations.

Source files
------------

// File: rtl/control_pkg.sv
// Shared control-unit definitions: microinstruction field positions,
// next-state select and condition select encodings, default vectors.
package control_pkg;

  localparam int CW_N_MSB     = 57;
  localparam int CW_N_LSB     = 55;
  localparam int CW_INV_BIT   = 54;
  localparam int CW_MI_BIT    = 53;
  localparam int CW_S_MSB     = 52;
  localparam int CW_S_LSB     = 50;
  localparam int CW_CRHI_MSB  = 49;
  localparam int CW_CRHI_LSB  = 42;
  localparam int CW_CRLO_MSB  = 41;
  localparam int CW_CRLO_LSB  = 34;

  typedef enum logic [2:0] {
    NS_ENC  = 3'b000,
    NS_CRHI = 3'b001,
    NS_INC  = 3'b010,
    NS_CBR  = 3'b011,
    NS_C2   = 3'b100,
    NS_CENC = 3'b101,
    NS_WAIT = 3'b110,
    NS_HOLD = 3'b111
  } nsel_e;

  typedef enum logic [2:0] {
    S_MOC   = 3'b000,
    S_CPASS = 3'b001,
    S_Z     = 3'b010,
    S_N     = 3'b011,
    S_C     = 3'b100,
    S_V     = 3'b101,
    S_LSM   = 3'b110,
    S_ONE   = 3'b111
  } csel_e;

  localparam logic [7:0] DEF_RESET_STATE = 8'd0;
  localparam logic [7:0] DEF_IRQ_STATE   = 8'd44;

endpackage

// File: rtl/cond_select.sv
// Microbranch condition: 8:1 select of status inputs, optionally inverted.
module cond_select
  import control_pkg::*;
(
  input  csel_e sel,
  input  logic  inv,
  input  logic  moc,
  input  logic  cond_pass,
  input  logic  flag_n,
  input  logic  flag_z,
  input  logic  flag_c,
  input  logic  flag_v,
  input  logic  lsm_done,
  output logic  cond
);

  logic raw;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    raw = 1'b1;
    case (sel)
      S_MOC:   raw = moc;
      S_CPASS: raw = cond_pass;
      S_Z:     raw = flag_z;
      S_N:     raw = flag_n;
      S_C:     raw = flag_c;
      S_V:     raw = flag_v;
      S_LSM:   raw = lsm_done;
      S_ONE:   raw = 1'b1;
    endcase
  end

  assign cond = raw ^ inv;

endmodule

// File: rtl/microsequencer.sv
// Control-ROM next-state engine: next-address select, memory-wait
// watchdog, interrupt override and the registered ROM address.
module microsequencer
  import control_pkg::*;
#(
  parameter logic [7:0] RESET_STATE = DEF_RESET_STATE,
  parameter logic [7:0] IRQ_STATE   = DEF_IRQ_STATE,
  parameter int         WAIT_LIMIT  = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [63:0] cw,
  input  logic [7:0]  enc_addr,
  input  logic        moc,
  input  logic        cond_pass,
  input  logic        flag_n,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_v,
  input  logic        lsm_done,
  input  logic        irq_req,
  output logic [7:0]  state,
  output logic        cond,
  output logic        timeout
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  nsel_e      n_sel;
  csel_e      c_sel;
  logic       inv, mi;
  logic [7:0] cr_hi, cr_lo, incr;
  logic [7:0] nx, sel_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       is_wait, wd_fire, irq_take;

  // Bits outside the sequencing fields belong to the datapath.
  logic unused_cw;
  assign unused_cw = ^{cw[63:58], cw[33:0]};

  assign n_sel = nsel_e'(cw[CW_N_MSB:CW_N_LSB]);
  assign c_sel = csel_e'(cw[CW_S_MSB:CW_S_LSB]);
  assign inv   = cw[CW_INV_BIT];
  assign mi    = cw[CW_MI_BIT];
  assign cr_hi = cw[CW_CRHI_MSB:CW_CRHI_LSB];
  assign cr_lo = cw[CW_CRLO_MSB:CW_CRLO_LSB];
  assign incr  = state + 8'd1;

  cond_select u_cond (
    .sel       (c_sel),
    .inv       (inv),
    .moc       (moc),
    .cond_pass (cond_pass),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .lsm_done  (lsm_done),
    .cond      (cond)
  );

  always_comb begin
    sel_nx = enc_addr;
    case (n_sel)
      NS_ENC:  sel_nx = enc_addr;
      NS_CRHI: sel_nx = cr_hi;
      NS_INC:  sel_nx = incr;
      NS_CBR:  sel_nx = cond ? cr_hi : incr;
      NS_C2:   sel_nx = cond ? cr_hi : cr_lo;
      NS_CENC: sel_nx = cond ? cr_hi : enc_addr;
      NS_WAIT: sel_nx = cond ? state : incr;
      NS_HOLD: sel_nx = state;
    endcase
  end

  assign is_wait  = (n_sel == NS_WAIT) && cond;
  assign wd_fire  = is_wait && (wait_cnt == WAIT_LAST);
  assign irq_take = mi && irq_req;

  // Watchdog expiry outranks the interrupt; both abandon the wait count.
  always_comb begin
    nx          = sel_nx;
    wait_cnt_nx = is_wait ? wait_cnt + 8'd1 : 8'd0;
    if (wd_fire) begin
      nx          = cr_lo;
      wait_cnt_nx = 8'd0;
    end else if (irq_take) begin
      nx          = IRQ_STATE;
      wait_cnt_nx = 8'd0;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= RESET_STATE;
      wait_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= nx;
      wait_cnt <= wait_cnt_nx;
      timeout  <= wd_fire;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer (WAIT_LIMIT=4): reset, fetch chain,
// dispatch, memory wait, watchdog, interrupt and condition mux sweep.
module tb_microsequencer;

  logic        CLK, CLR;
  logic [63:0] cw;
  logic [7:0]  enc_addr;
  logic        moc, cond_pass, flag_n, flag_z, flag_c, flag_v, lsm_done, irq_req;
  logic [7:0]  state;
  logic        cond, timeout;

  int checks = 0;
  int errors = 0;

  microsequencer #(
    .RESET_STATE (8'd0),
    .IRQ_STATE   (8'd44),
    .WAIT_LIMIT  (4)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .cw        (cw),
    .enc_addr  (enc_addr),
    .moc       (moc),
    .cond_pass (cond_pass),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .lsm_done  (lsm_done),
    .irq_req   (irq_req),
    .state     (state),
    .cond      (cond),
    .timeout   (timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] mk_cw(input logic [2:0] n, input logic inv, input logic mi,
                                        input logic [2:0] s, input logic [7:0] hi, input logic [7:0] lo);
    logic [63:0] w;
    w        = 64'hA5A5_0000_0000_0000 & ~(64'h03FF_FFFC_0000_0000);
    w[57:55] = n;
    w[54]    = inv;
    w[53]    = mi;
    w[52:50] = s;
    w[49:42] = hi;
    w[41:34] = lo;
    return w;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    CLR = 1'b1;
    cw  = mk_cw(3'b010, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    #2;
    checks++; if (state !== 8'd0) begin errors++; $display("FAIL reset_state got %h want 00", state); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    tick;
    checks++; if (state !== 8'd0) begin errors++; $display("FAIL reset_hold got %h want 00", state); end
    CLR = 1'b0;
    cw  = mk_cw(3'b001, 1'b0, 1'b0, 3'b000, 8'h77, 8'h00);
    tick;
    checks++; if (state !== 8'h77) begin errors++; $display("FAIL load_crhi got %h want 77", state); end
    cw = mk_cw(3'b010, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    #3 CLR = 1'b1;
    #1;
    checks++; if (state !== 8'd0) begin errors++; $display("FAIL async_clr got %h want 00", state); end
    tick;
    checks++; if (state !== 8'd0) begin errors++; $display("FAIL clr_priority got %h want 00", state); end
    CLR = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      checks++; if (state !== 8'(i)) begin errors++; $display("FAIL fetch_chain got %h want %h", state, 8'(i)); end
    end
  endtask

  task automatic test_wrap;
    cw = mk_cw(3'b001, 1'b0, 1'b0, 3'b000, 8'hFF, 8'h00);
    tick;
    checks++; if (state !== 8'hFF) begin errors++; $display("FAIL wrap_load got %h want ff", state); end
    cw = mk_cw(3'b010, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    tick;
    checks++; if (state !== 8'h00) begin errors++; $display("FAIL wrap_incr got %h want 00", state); end
  endtask

  task automatic test_dispatch;
    cw = mk_cw(3'b001, 1'b0, 1'b0, 3'b000, 8'd3, 8'd0);
    tick;
    enc_addr = 8'd25;
    cw = mk_cw(3'b000, 1'b0, 1'b0, 3'b000, 8'd99, 8'd98);
    tick;
    checks++; if (state !== 8'd25) begin errors++; $display("FAIL dispatch_enc got %0d want 25", state); end
    cond_pass = 1'b0;
    cw = mk_cw(3'b100, 1'b0, 1'b0, 3'b001, 8'd30, 8'd40);
    tick;
    checks++; if (state !== 8'd40) begin errors++; $display("FAIL c2_false got %0d want 40", state); end
    cond_pass = 1'b1;
    tick;
    checks++; if (state !== 8'd30) begin errors++; $display("FAIL c2_true got %0d want 30", state); end
    cond_pass = 1'b0;
    cw = mk_cw(3'b011, 1'b0, 1'b0, 3'b001, 8'd70, 8'd40);
    tick;
    checks++; if (state !== 8'd31) begin errors++; $display("FAIL cbr_false got %0d want 31", state); end
    cw = mk_cw(3'b011, 1'b1, 1'b0, 3'b001, 8'd70, 8'd40);
    tick;
    checks++; if (state !== 8'd70) begin errors++; $display("FAIL cbr_inv got %0d want 70", state); end
    enc_addr = 8'd12;
    cw = mk_cw(3'b101, 1'b0, 1'b0, 3'b001, 8'd80, 8'd40);
    tick;
    checks++; if (state !== 8'd12) begin errors++; $display("FAIL cenc_false got %0d want 12", state); end
    cw = 64'h0;
    enc_addr = 8'd9;
    tick;
    checks++; if (state !== 8'd9) begin errors++; $display("FAIL zero_row got %0d want 9", state); end
  endtask

  task automatic test_mem_wait;
    cw = mk_cw(3'b001, 1'b0, 1'b0, 3'b000, 8'd10, 8'd0);
    tick;
    for (int r = 0; r < 2; r++) begin
      moc = 1'b0;
      cw  = mk_cw(3'b110, 1'b1, 1'b0, 3'b000, 8'd0, 8'd50);
      for (int i = 0; i < 3; i++) begin
        tick;
        checks++; if (state !== 8'(10 + r) || timeout !== 1'b0) begin
          errors++; $display("FAIL mem_wait_hold got %0d/%b want %0d/0", state, timeout, 10 + r);
        end
      end
      moc = 1'b1;
      tick;
      checks++; if (state !== 8'(11 + r) || timeout !== 1'b0) begin
        errors++; $display("FAIL mem_wait_done got %0d/%b want %0d/0", state, timeout, 11 + r);
      end
    end
  endtask

  task automatic test_watchdog;
    moc = 1'b0;
    cw  = mk_cw(3'b110, 1'b1, 1'b0, 3'b000, 8'd0, 8'd50);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (state !== 8'd12 || timeout !== 1'b0) begin
        errors++; $display("FAIL wd_hold got %0d/%b want 12/0", state, timeout);
      end
    end
    tick;
    checks++; if (state !== 8'd50 || timeout !== 1'b1) begin
      errors++; $display("FAIL wd_fire got %0d/%b want 50/1", state, timeout);
    end
    cw = mk_cw(3'b111, 1'b0, 1'b0, 3'b000, 8'd0, 8'd60);
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++; if (state !== 8'd50 || timeout !== 1'b0) begin
        errors++; $display("FAIL hold_no_timeout got %0d/%b want 50/0", state, timeout);
      end
    end
  endtask

  task automatic test_interrupt;
    irq_req = 1'b1;
    cw = mk_cw(3'b010, 1'b0, 1'b1, 3'b000, 8'd0, 8'd0);
    tick;
    checks++; if (state !== 8'd44) begin errors++; $display("FAIL irq_taken got %0d want 44", state); end
    cw = mk_cw(3'b010, 1'b0, 1'b0, 3'b000, 8'd0, 8'd0);
    tick;
    checks++; if (state !== 8'd45) begin errors++; $display("FAIL irq_masked got %0d want 45", state); end
    moc = 1'b0;
    cw  = mk_cw(3'b110, 1'b1, 1'b0, 3'b000, 8'd0, 8'd50);
    repeat (3) tick;
    checks++; if (state !== 8'd45) begin errors++; $display("FAIL irq_wait_hold got %0d want 45", state); end
    cw = mk_cw(3'b110, 1'b1, 1'b1, 3'b000, 8'd0, 8'd50);
    tick;
    checks++; if (state !== 8'd50 || timeout !== 1'b1) begin
      errors++; $display("FAIL wd_beats_irq got %0d/%b want 50/1", state, timeout);
    end
    tick;
    checks++; if (state !== 8'd44 || timeout !== 1'b0) begin
      errors++; $display("FAIL irq_after_wd got %0d/%b want 44/0", state, timeout);
    end
    irq_req = 1'b0;
    moc = 1'b1;
  endtask

  task automatic test_cond_sweep;
    logic exp;
    for (int s = 0; s < 8; s++) begin
      for (int raw = 0; raw < 2; raw++) begin
        for (int inv = 0; inv < 2; inv++) begin
          moc       = (s == 0) ? raw[0] : ~raw[0];
          cond_pass = (s == 1) ? raw[0] : ~raw[0];
          flag_z    = (s == 2) ? raw[0] : ~raw[0];
          flag_n    = (s == 3) ? raw[0] : ~raw[0];
          flag_c    = (s == 4) ? raw[0] : ~raw[0];
          flag_v    = (s == 5) ? raw[0] : ~raw[0];
          lsm_done  = (s == 6) ? raw[0] : ~raw[0];
          cw  = mk_cw(3'b111, inv[0], 1'b0, 3'(s), 8'd0, 8'd0);
          exp = ((s == 7) ? 1'b1 : raw[0]) ^ inv[0];
          #1;
          checks++; if (cond !== exp) begin
            errors++; $display("FAIL cond_s%0d_raw%0d_inv%0d got %b want %b", s, raw, inv, cond, exp);
          end
        end
      end
    end
  endtask

  initial begin
    CLR = 1'b1; cw = '0; enc_addr = '0; moc = 1'b1; cond_pass = 1'b0;
    flag_n = 1'b0; flag_z = 1'b0; flag_c = 1'b0; flag_v = 1'b0;
    lsm_done = 1'b0; irq_req = 1'b0;
    test_reset;
    test_wrap;
    test_dispatch;
    test_mem_wait;
    test_watchdog;
    test_interrupt;
    test_cond_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
